// File: rtl/gpio_reg_file.sv
// gpio_reg_file: far-end responder of the MicroBlaze GPIO link. Decodes strobed command
// words from gpo0, drives soft reset / control outputs, captures a block of DSP samples
// into a log RAM and returns readback data on gpi0.
// Optional feature macro: RF_LOG_TRIGGER_EN adds an ARMED state that waits for
// i_log_trigger before capture starts.
module gpio_reg_file #(
    parameter int unsigned NB_GPIOS    = 32,
    parameter int unsigned NB_CTRL     = 8,
    parameter int unsigned NB_LOG_DATA = 32,
    parameter int unsigned NB_LOG_ADDR = 10
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic [NB_GPIOS-1:0]    i_gpo,
    output logic [NB_GPIOS-1:0]    o_gpi,
    output logic                   o_soft_reset,
    output logic [NB_CTRL-1:0]     o_ctrl,
    input  logic [NB_LOG_DATA-1:0] i_log_data,
    input  logic                   i_log_valid,
    input  logic                   i_log_trigger,
    output logic                   o_log_done
);

    localparam int unsigned Depth = 2 ** NB_LOG_ADDR;

    localparam logic [7:0] OpSoftRst   = 8'h01;
    localparam logic [7:0] OpCtrlWr    = 8'h02;
    localparam logic [7:0] OpCtrlRd    = 8'h03;
    localparam logic [7:0] OpLogRun    = 8'h04;
    localparam logic [7:0] OpLogStatus = 8'h05;
    localparam logic [7:0] OpLogRead   = 8'h06;

`ifdef RF_LOG_TRIGGER_EN
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDone  = 2'b10,
        StArmed = 2'b11
    } log_state_e;
    localparam log_state_e StStart = StArmed;
`else
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } log_state_e;
    localparam log_state_e StStart = StRun;
`endif

    logic [NB_GPIOS-1:0]    gpo_q;
    logic                   strobe_prev_q;
    logic [7:0]             opcode;
    logic                   strobe;
    logic [22:0]            payload;
    logic                   exec;

    logic                   cmd_soft_rst;
    logic                   cmd_ctrl_wr;
    logic                   cmd_ctrl_rd;
    logic                   cmd_log_run;
    logic                   cmd_log_status;
    logic                   cmd_log_read;
    logic                   cmd_unknown;

    log_state_e             state_q;
    logic [NB_LOG_ADDR-1:0] count_q;
    logic                   log_we;

    logic [NB_LOG_DATA-1:0] mem [Depth];
    logic [NB_LOG_DATA-1:0] ram_rdata_q;

    logic                   rsp_valid_q;
    logic                   rsp_from_ram_q;
    logic [NB_GPIOS-1:0]    rsp_word_q;
    logic [NB_GPIOS-1:0]    ctrl_ext;
    logic [NB_GPIOS-1:0]    status_ext;
    logic [NB_GPIOS-1:0]    ram_ext;

    // Payload bits beyond the widest field are don't-care.
    logic                   unused_inputs;

    assign opcode  = gpo_q[31:24];
    assign strobe  = gpo_q[23];
    assign payload = gpo_q[22:0];
    assign exec    = strobe & ~strobe_prev_q;

`ifdef RF_LOG_TRIGGER_EN
    assign unused_inputs = ^payload;
`else
    assign unused_inputs = ^{payload, i_log_trigger};
`endif

    // Input register and strobe history for rising-edge command execution.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            gpo_q         <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            gpo_q         <= i_gpo;
            strobe_prev_q <= strobe;
        end
    end

    // Command decode, qualified by the strobe rising edge.
    always_comb begin
        cmd_soft_rst   = exec && (opcode == OpSoftRst);
        cmd_ctrl_wr    = exec && (opcode == OpCtrlWr);
        cmd_ctrl_rd    = exec && (opcode == OpCtrlRd);
        cmd_log_run    = exec && (opcode == OpLogRun);
        cmd_log_status = exec && (opcode == OpLogStatus);
        cmd_log_read   = exec && (opcode == OpLogRead);
        cmd_unknown    = exec && !(opcode inside {OpSoftRst, OpCtrlWr, OpCtrlRd,
                                                   OpLogRun, OpLogStatus, OpLogRead});
    end

    // Soft reset and control register writes.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_soft_reset <= 1'b0;
            o_ctrl       <= '0;
        end else begin
            if (cmd_soft_rst) o_soft_reset <= payload[0];
            if (cmd_ctrl_wr)  o_ctrl       <= payload[NB_CTRL-1:0];
        end
    end

    // A sample is written while running, or on the trigger cycle out of ARMED.
    // LOG_RUN takes priority so a restart never writes at the stale count.
    always_comb begin
        log_we = i_log_valid && !cmd_log_run && (state_q == StRun);
`ifdef RF_LOG_TRIGGER_EN
        if (i_log_valid && !cmd_log_run && (state_q == StArmed) && i_log_trigger) begin
            log_we = 1'b1;
        end
`endif
    end

    // Log capture FSM: sample counter, state and done flag.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            o_log_done <= 1'b0;
        end else if (cmd_log_run) begin
            state_q    <= StStart;
            count_q    <= '0;
            o_log_done <= 1'b0;
        end else begin
            if (log_we) count_q <= count_q + NB_LOG_ADDR'(1);
            if (log_we && (count_q == '1)) begin
                state_q    <= StDone;
                o_log_done <= 1'b1;
            end
`ifdef RF_LOG_TRIGGER_EN
            else if ((state_q == StArmed) && i_log_trigger) begin
                state_q <= StRun;
            end
`endif
        end
    end

    // Log RAM: single write port, registered read-first read port.
    always_ff @(posedge clock) begin
        if (log_we) mem[count_q] <= i_log_data;
        ram_rdata_q <= mem[payload[NB_LOG_ADDR-1:0]];
    end

    // Zero-extended response sources.
    always_comb begin
        ctrl_ext                      = '0;
        ctrl_ext[NB_CTRL-1:0]         = o_ctrl;
        status_ext                    = '0;
        status_ext[2:1]               = state_q;
        status_ext[0]                 = o_log_done;
        ram_ext                       = '0;
        ram_ext[NB_LOG_DATA-1:0]      = ram_rdata_q;
    end

    // Response select stage, aligned with the RAM read.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rsp_valid_q    <= 1'b0;
            rsp_from_ram_q <= 1'b0;
            rsp_word_q     <= '0;
        end else begin
            rsp_valid_q    <= cmd_ctrl_rd | cmd_log_status | cmd_log_read | cmd_unknown;
            rsp_from_ram_q <= cmd_log_read;
            if (cmd_unknown)      rsp_word_q <= '1;
            else if (cmd_ctrl_rd) rsp_word_q <= ctrl_ext;
            else                  rsp_word_q <= status_ext;
        end
    end

    // Response register: holds until the next read-type or unknown command.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_gpi <= '0;
        end else if (rsp_valid_q) begin
            o_gpi <= rsp_from_ram_q ? ram_ext : rsp_word_q;
        end
    end

endmodule

// File: tb/tb_gpio_reg_file.sv
// Self-checking bench for gpio_reg_file: read responses go through an expected-value queue.
module tb_gpio_reg_file;

    logic        clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic        o_soft_reset;
    logic [7:0]  o_ctrl;
    logic [31:0] i_log_data;
    logic        i_log_valid;
    logic        i_log_trigger;
    logic        o_log_done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_gpi;

    always #5 clock = ~clock;

    gpio_reg_file dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_gpo         (i_gpo),
        .o_gpi         (o_gpi),
        .o_soft_reset  (o_soft_reset),
        .o_ctrl        (o_ctrl),
        .i_log_data    (i_log_data),
        .i_log_valid   (i_log_valid),
        .i_log_trigger (i_log_trigger),
        .o_log_done    (o_log_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one strobed command; reads push an expected value and are checked 3 clocks on.
    task automatic cmd(input logic [7:0] op, input logic [22:0] pl, input bit rd,
                       input logic [31:0] exp, input bit pulse_log, input logic [31:0] pdata);
        logic [31:0] e;
        @(negedge clock);
        i_gpo = {op, 1'b1, pl};
        if (rd) exp_q.push_back(exp);
        @(negedge clock);
        i_gpo[23] = 1'b0;
        if (pulse_log) begin
            i_log_valid   = 1'b1;
            i_log_data    = pdata;
            i_log_trigger = 1'b1;
        end
        @(posedge clock);
        #1;
        check($sformatf("op%02h_gpi_hold", op), o_gpi, last_gpi);
        @(negedge clock);
        i_log_valid   = 1'b0;
        i_log_trigger = 1'b0;
        @(posedge clock);
        #1;
        if (rd) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("op%02h_gpi", op), o_gpi, e);
                last_gpi = e;
            end
        end else begin
            check($sformatf("op%02h_gpi_keep", op), o_gpi, last_gpi);
        end
    endtask

    // Drive n valid samples (data = base + index) with random idle gaps.
    task automatic capture(input int n, input logic [31:0] base);
        int i;
        i = 0;
        while (i < n) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                i_log_valid = 1'b0;
            end else begin
                i_log_valid = 1'b1;
                i_log_data  = base + i;
                i++;
            end
        end
        @(negedge clock);
        i_log_valid = 1'b0;
    endtask

    // Start a capture so that the next valid lands at address 0.
    task automatic start_run();
        cmd(8'h04, 23'h0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef RF_LOG_TRIGGER_EN
        @(negedge clock);
        i_log_trigger = 1'b1;
        @(negedge clock);
        i_log_trigger = 1'b0;
`endif
    endtask

    initial begin
        int a;
        i_reset       = 1'b0;
        i_gpo         = '0;
        i_log_data    = '0;
        i_log_valid   = 1'b0;
        i_log_trigger = 1'b0;
        last_gpi      = '0;
        repeat (3) @(negedge clock);
        check("rst_gpi", o_gpi, 32'h0);
        check("rst_ctrl", {24'h0, o_ctrl}, 32'h0);
        check("rst_soft", {31'h0, o_soft_reset}, 32'h0);
        check("rst_done", {31'h0, o_log_done}, 32'h0);
        i_reset = 1'b1;

        // Control write/read with exact latency.
        cmd(8'h02, 23'h5A, 1'b0, 32'h0, 1'b0, 32'h0);
        check("ctrl_wr", {24'h0, o_ctrl}, 32'h5A);
        cmd(8'h03, 23'h0, 1'b1, 32'h0000_005A, 1'b0, 32'h0);

        // Strobe held high: only the first payload executes.
        @(negedge clock);
        i_gpo = {8'h02, 1'b1, 23'h11};
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            i_gpo[22:0] = 23'h20 + 23'(k);
        end
        @(negedge clock);
        i_gpo[23] = 1'b0;
        repeat (3) @(negedge clock);
        check("ctrl_held", {24'h0, o_ctrl}, 32'h11);

        // Soft reset touches nothing else.
        cmd(8'h01, 23'h1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("soft_set", {31'h0, o_soft_reset}, 32'h1);
        check("soft_ctrl", {24'h0, o_ctrl}, 32'h11);
        cmd(8'h01, 23'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("soft_clr", {31'h0, o_soft_reset}, 32'h0);

        // Full capture with status before, during and after.
        cmd(8'h05, 23'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        start_run();
        capture(500, 32'h0);
        cmd(8'h05, 23'h0, 1'b1, 32'h2, 1'b0, 32'h0);
        capture(523, 32'd500);
        check("done_early", {31'h0, o_log_done}, 32'h0);
        capture(1, 32'd1023);
        check("done_set", {31'h0, o_log_done}, 32'h1);
        cmd(8'h05, 23'h0, 1'b1, 32'h5, 1'b0, 32'h0);
        capture(5, 32'hDEAD_0000);
        check("done_hold", {31'h0, o_log_done}, 32'h1);
        cmd(8'h06, 23'h000, 1'b1, 32'd0, 1'b0, 32'h0);
        cmd(8'h06, 23'h005, 1'b1, 32'd5, 1'b0, 32'h0);
        cmd(8'h06, 23'h405, 1'b1, 32'd5, 1'b0, 32'h0);
        cmd(8'h06, 23'h3FF, 1'b1, 32'd1023, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(0, 1023);
            cmd(8'h06, 23'(a), 1'b1, 32'(a), 1'b0, 32'h0);
        end

        // Unknown opcode.
        cmd(8'h7F, 23'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        check("unk_ctrl", {24'h0, o_ctrl}, 32'h11);
        cmd(8'h03, 23'h0, 1'b1, 32'h11, 1'b0, 32'h0);

        // Read-first: write and read of address 0 in the same cycle.
        cmd(8'h04, 23'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cmd(8'h06, 23'h0, 1'b1, 32'd0, 1'b1, 32'hAAAA_5555);
        cmd(8'h06, 23'h0, 1'b1, 32'hAAAA_5555, 1'b0, 32'h0);
        cmd(8'h06, 23'h1, 1'b1, 32'd1, 1'b0, 32'h0);

        // Reset asserted at sample 300 of a capture.
        cmd(8'h01, 23'h1, 1'b0, 32'h0, 1'b0, 32'h0);
        start_run();
        capture(300, 32'h1000_0000);
        @(negedge clock);
        i_reset     = 1'b0;
        i_log_valid = 1'b1;
        i_log_data  = 32'h0000_BEEF;
        #1;
        check("mid_rst_gpi", o_gpi, 32'h0);
        check("mid_rst_ctrl", {24'h0, o_ctrl}, 32'h0);
        check("mid_rst_soft", {31'h0, o_soft_reset}, 32'h0);
        check("mid_rst_done", {31'h0, o_log_done}, 32'h0);
        last_gpi = '0;
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        repeat (4) @(negedge clock);
        i_log_valid = 1'b0;
        cmd(8'h05, 23'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        cmd(8'h06, 23'd300, 1'b1, 32'd300, 1'b0, 32'h0);
        cmd(8'h06, 23'd299, 1'b1, 32'h1000_0000 + 32'd299, 1'b0, 32'h0);
        cmd(8'h06, 23'd0, 1'b1, 32'h1000_0000, 1'b0, 32'h0);

`ifdef RF_LOG_TRIGGER_EN
        // Triggered capture: samples before the trigger are dropped.
        cmd(8'h04, 23'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        cmd(8'h05, 23'h0, 1'b1, 32'h6, 1'b0, 32'h0);
        capture(50, 32'h2000_0000);
        @(negedge clock);
        i_log_trigger = 1'b1;
        i_log_valid   = 1'b1;
        i_log_data    = 32'h3000_0000;
        @(negedge clock);
        i_log_trigger = 1'b0;
        i_log_valid   = 1'b0;
        capture(1023, 32'h3000_0001);
        check("trig_done", {31'h0, o_log_done}, 32'h1);
        cmd(8'h06, 23'h0, 1'b1, 32'h3000_0000, 1'b0, 32'h0);
        cmd(8'h06, 23'h1, 1'b1, 32'h3000_0001, 1'b0, 32'h0);
        cmd(8'h06, 23'h3FF, 1'b1, 32'h3000_03FF, 1'b0, 32'h0);
        cmd(8'h05, 23'h0, 1'b1, 32'h5, 1'b0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_reg_file.md
Name: gpio_reg_file

Overview:
- Register-file responder on the far end of the MicroBlaze GPIO link.
- Decodes command words that firmware writes on the GPIO output bus (gpo0). Drives control outputs into the DSP datapath.
- Captures a block of DSP samples into an internal log RAM.
- Returns status, readback and log data on the GPIO input bus (gpi0) for firmware to poll.

Parameters:
- NB_GPIOS, 32, width of the GPIO command and response words.
- NB_CTRL, 8, width of the control register.
- NB_LOG_DATA, 32, log sample width; must be at most NB_GPIOS.
- NB_LOG_ADDR, 10, log RAM address width; depth = 2**NB_LOG_ADDR.

Ports:
- clock, in, 1: DSP/application clock. This is the same clock that drives the MicroBlaze GPIO.
- i_reset, in, 1: asynchronous, active-low reset.
- i_gpo, in, NB_GPIOS: command word from the micro.
- o_gpi, out, NB_GPIOS: response word to the micro.
- o_soft_reset, out, 1: soft reset to the DSP datapath, active-high level.
- o_ctrl, out, NB_CTRL: control register (enables, selects).
- i_log_data, in, NB_LOG_DATA: sample to capture.
- i_log_valid, in, 1: sample qualifier.
- i_log_trigger, in, 1: capture trigger. Used only when the optional feature is compiled in.
- o_log_done, out, 1: log RAM full.

Behaviour:
- Command word fields:
  - [31:24] opcode.
  - [23] strobe.
  - [22:0] payload.
- i_gpo is registered once. A command executes in the cycle after a 0->1 transition of the registered strobe.
  - One execution per rising edge.
  - Holding strobe high never re-executes.
  - Firmware must drop strobe before the next command.
- Opcodes:
  - 0x01 SOFT_RST: o_soft_reset <= payload[0].
  - 0x02 CTRL_WR: o_ctrl <= payload[NB_CTRL-1:0].
  - 0x03 CTRL_RD: o_gpi <= zero-extended o_ctrl.
  - 0x04 LOG_RUN: clears the sample counter and o_log_done, then enters RUN.
  - 0x05 LOG_STATUS: o_gpi <= {zeros, state[1:0], o_log_done}.
  - 0x06 LOG_READ: o_gpi <= zero-extended mem[payload[NB_LOG_ADDR-1:0]]. Upper address bits are ignored, so the address wraps modulo depth.
  - Any other opcode: o_gpi <= 32'hFFFF_FFFF. No other state changes.
- Latency: o_gpi reflects a read result 3 clocks after i_gpo strobe rises at the block input.
  - Cycle 1: input register.
  - Cycle 2: edge detect and RAM read.
  - Cycle 3: o_gpi register.
- o_gpi holds its value until the next read-type or unknown command. Write commands leave o_gpi unchanged.
- Log FSM states:
  - IDLE (00)
  - RUN (01)
  - DONE (10)
  - ARMED (11), exists only with the optional feature.
- Log FSM transitions:
  - RUN: each cycle with i_log_valid=1 writes i_log_data to mem[count] and increments count.
  - RUN -> DONE when the write at count = depth-1 occurs. o_log_done is set the next cycle, and count wraps to 0.
  - DONE: further valids are ignored, and o_log_done stays 1.
  - LOG_RUN in any state restarts from count 0. The RAM is not cleared.
- LOG_READ during RUN is legal and returns current RAM contents. A same-cycle write/read to the same address returns old data (read-first).
- SOFT_RST affects only o_soft_reset; the log FSM and o_ctrl are untouched.
- Reset values: o_gpi=0, o_soft_reset=0, o_ctrl=0, o_log_done=0, state=IDLE, count=0, registered strobe=0. RAM contents are undefined.
- Reset asserted mid-capture: returns to IDLE immediately. No further RAM writes occur after reset.

Optional Feature:
- Macro: RF_LOG_TRIGGER_EN.
- Defined:
  - LOG_RUN enters ARMED.
  - ARMED -> RUN on the first cycle with i_log_trigger=1. That same cycle's sample is captured if i_log_valid=1.
  - LOG_RUN while ARMED re-arms.
  - LOG_STATUS reports state 11.
- Undefined:
  - LOG_RUN enters RUN directly.
  - i_log_trigger is ignored.
  - ARMED state does not exist.

Test Plan:
- Reset, then CTRL_WR payload 0x5A with strobe pulsed -> o_ctrl=0x5A. CTRL_RD -> o_gpi=0x0000005A exactly 3 clocks after strobe.
- Strobe held high for 10 cycles with opcode CTRL_WR and payload changing -> only the first payload is latched.
- LOG_RUN, then drive 1024 valids with data=index, with valid gaps -> o_log_done=1 after the last write. LOG_READ addr 0x005 -> 5. LOG_READ payload 0x405 -> 5 (wrap).
- LOG_STATUS before, during and after capture -> 0, 1, 2 in bits [2:1]. Valids after DONE do not alter mem[0].
- Opcode 0x7F -> o_gpi=0xFFFFFFFF with o_ctrl unchanged. i_reset pulsed low at sample 300 of a capture -> state IDLE, o_log_done=0, all outputs 0.
- With RF_LOG_TRIGGER_EN: LOG_RUN, 50 valids, trigger, 1024 valids -> mem[0] = first sample on the trigger cycle. LOG_STATUS before the trigger -> state 11.
